// File: rtl/prga_stream.sv
// prga_stream: RC4 keystream generator / stream decryptor over a
// pre-scheduled S memory of 2^W words. Reads a length-prefixed ciphertext,
// writes a length-prefixed result, and can stop early on the first
// non-printable plaintext word.
module prga_stream #(
    parameter int unsigned W      = 8,
    parameter int unsigned CHK_LO = 8'h20,
    parameter int unsigned CHK_HI = 8'h7E
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    output logic         o_rdy,
    input  logic         i_mode,
    input  logic         i_chk_en,
    output logic [W-1:0] o_s_addr,
    input  logic [W-1:0] i_s_rddata,
    output logic [W-1:0] o_s_wrdata,
    output logic         o_s_wren,
    output logic [W-1:0] o_ct_addr,
    input  logic [W-1:0] i_ct_rddata,
    output logic [W-1:0] o_pt_addr,
    input  logic [W-1:0] i_pt_rddata,
    output logic [W-1:0] o_pt_wrdata,
    output logic         o_pt_wren,
    output logic         o_valid,
    output logic [W-1:0] o_fail_idx,
    output logic         o_done
);

    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RDLEN,
        ST_WRLEN,
        ST_RDI,
        ST_WAITI,
        ST_RDJ,
        ST_WAITJ,
        ST_WRI,
        ST_WRJ,
        ST_RDP,
        ST_WAITP,
        ST_XOR
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [W-1:0] r_i;
    logic [W-1:0] r_j;
    logic [W-1:0] r_k;
    logic [W-1:0] r_len;
    logic [W-1:0] r_si;
    logic [W-1:0] r_sj;
    logic [W-1:0] r_pad;
    logic [W-1:0] r_c;
    logic         r_mode;
    logic         r_chkEn;
    logic         r_valid;
    logic [W-1:0] r_failIdx;
    logic         r_done;

    logic [W-1:0] w_ptData;
    logic         w_outOfRange;
    logic         w_chkFail;
    logic         w_unused;

    // The PT read port exists for memory symmetry but the result is never needed.
    assign w_unused = ^i_pt_rddata;

    // Result word: raw pad in keystream mode, otherwise ciphertext XOR pad.
    assign w_ptData     = r_mode ? r_pad : (r_c ^ r_pad);
    assign w_outOfRange = (32'(w_ptData) < CHK_LO) || (32'(w_ptData) > CHK_HI);
    assign w_chkFail    = r_chkEn && !r_mode && r_valid && w_outOfRange;

    assign o_rdy      = (r_state == ST_IDLE);
    assign o_valid    = r_valid;
    assign o_fail_idx = r_failIdx;
    assign o_done     = r_done;

    // State register; reset returns to IDLE immediately, even mid-run.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and memory-port decode; all ports idle unless a state drives them.
    always_comb begin
        w_nextState = r_state;
        o_s_addr    = '0;
        o_s_wrdata  = '0;
        o_s_wren    = 1'b0;
        o_ct_addr   = '0;
        o_pt_addr   = '0;
        o_pt_wrdata = '0;
        o_pt_wren   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_en) begin
                    w_nextState = ST_RDLEN;
                end
            end
            ST_RDLEN: begin
                o_ct_addr   = '0;
                w_nextState = ST_WRLEN;
            end
            ST_WRLEN: begin
                o_pt_addr   = '0;
                o_pt_wrdata = i_ct_rddata;
                o_pt_wren   = 1'b1;
                w_nextState = (i_ct_rddata == '0) ? ST_IDLE : ST_RDI;
            end
            ST_RDI: begin
                o_s_addr    = r_i;
                w_nextState = ST_WAITI;
            end
            ST_WAITI: begin
                o_s_addr    = r_i;
                w_nextState = ST_RDJ;
            end
            ST_RDJ: begin
                o_s_addr    = r_j;
                w_nextState = ST_WAITJ;
            end
            ST_WAITJ: begin
                o_s_addr    = r_j;
                w_nextState = ST_WRI;
            end
            ST_WRI: begin
                o_s_addr    = r_i;
                o_s_wrdata  = r_sj;
                o_s_wren    = 1'b1;
                w_nextState = ST_WRJ;
            end
            ST_WRJ: begin
                o_s_addr    = r_j;
                o_s_wrdata  = r_si;
                o_s_wren    = 1'b1;
                w_nextState = ST_RDP;
            end
            ST_RDP: begin
                o_s_addr    = r_si + r_sj;
                o_ct_addr   = r_k;
                w_nextState = ST_WAITP;
            end
            ST_WAITP: begin
                o_s_addr    = r_si + r_sj;
                o_ct_addr   = r_k;
                w_nextState = ST_XOR;
            end
            ST_XOR: begin
                o_pt_addr   = r_k;
                o_pt_wrdata = w_ptData;
                o_pt_wren   = 1'b1;
                if (w_chkFail || (r_k == r_len)) begin
                    w_nextState = ST_IDLE;
                end else begin
                    w_nextState = ST_RDI;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Datapath: swap indices, captured S/CT words, word counter and run status.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_len     <= '0;
            r_si      <= '0;
            r_sj      <= '0;
            r_pad     <= '0;
            r_c       <= '0;
            r_mode    <= 1'b0;
            r_chkEn   <= 1'b0;
            r_valid   <= 1'b0;
            r_failIdx <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_en) begin
                        r_i       <= '0;
                        r_j       <= '0;
                        r_failIdx <= '0;
                        r_valid   <= 1'b1;
                        r_mode    <= i_mode;
                        r_chkEn   <= i_chk_en;
                    end
                end
                ST_WRLEN: begin
                    r_len <= i_ct_rddata;
                    r_k   <= ONE;
                    if (i_ct_rddata == '0) begin
                        r_done <= 1'b1;
                    end else begin
                        r_i <= r_i + ONE;
                    end
                end
                ST_WAITI: begin
                    r_si <= i_s_rddata;
                    r_j  <= r_j + i_s_rddata;
                end
                ST_WAITJ: begin
                    r_sj <= i_s_rddata;
                end
                ST_WAITP: begin
                    r_pad <= i_s_rddata;
                    r_c   <= i_ct_rddata;
                end
                ST_XOR: begin
                    if (w_chkFail) begin
                        r_valid   <= 1'b0;
                        r_failIdx <= r_k;
                        r_done    <= 1'b1;
                    end else if (r_k == r_len) begin
                        r_done <= 1'b1;
                    end else begin
                        r_k <= r_k + ONE;
                        r_i <= r_i + ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prga_stream.sv
// tb_prga_stream: drives a W=8 and a W=4 instance of prga_stream with
// directed and random runs and compares them against an RC4 model.
module tb_prga_stream;

    localparam int unsigned LO0 = 8'h20;
    localparam int unsigned HI0 = 8'h7E;
    localparam int unsigned LO1 = 2;
    localparam int unsigned HI1 = 13;

    logic clk;
    logic rstN;
    logic [1:0] en;
    logic [1:0] mode;
    logic [1:0] chk;

    wire [1:0][7:0] sAddr;
    wire [1:0][7:0] sWrdata;
    wire [1:0][7:0] ctAddr;
    wire [1:0][7:0] ptAddr;
    wire [1:0][7:0] ptWrdata;
    wire [1:0][7:0] failIdx;
    wire [1:0]      sWren;
    wire [1:0]      ptWren;
    wire [1:0]      rdy;
    wire [1:0]      valid;
    wire [1:0]      done;

    wire [3:0] sAddr4;
    wire [3:0] sWrdata4;
    wire [3:0] ctAddr4;
    wire [3:0] ptAddr4;
    wire [3:0] ptWrdata4;
    wire [3:0] failIdx4;

    logic [1:0][7:0] sRd;
    logic [1:0][7:0] ctRd;
    logic [1:0][7:0] ptRd;

    logic [7:0] sMem  [2][256];
    logic [7:0] ctMem [2][256];
    logic [7:0] ptMem [2][256];

    logic       ldS;
    logic       ldCt;
    int         ldInst;
    logic [7:0] ldAddr;
    logic [7:0] ldData;

    int mS [2][256];
    int ctBuf [256];
    int expAddr[$];
    int expData[$];
    int expBusy;
    int expValid;
    int expFail;
    int tests;
    int fails;

    prga_stream #(.W(8), .CHK_LO(LO0), .CHK_HI(HI0)) dut8 (
        .i_clk(clk), .i_rst_n(rstN), .i_en(en[0]), .o_rdy(rdy[0]),
        .i_mode(mode[0]), .i_chk_en(chk[0]),
        .o_s_addr(sAddr[0]), .i_s_rddata(sRd[0]), .o_s_wrdata(sWrdata[0]), .o_s_wren(sWren[0]),
        .o_ct_addr(ctAddr[0]), .i_ct_rddata(ctRd[0]),
        .o_pt_addr(ptAddr[0]), .i_pt_rddata(ptRd[0]), .o_pt_wrdata(ptWrdata[0]), .o_pt_wren(ptWren[0]),
        .o_valid(valid[0]), .o_fail_idx(failIdx[0]), .o_done(done[0])
    );

    prga_stream #(.W(4), .CHK_LO(LO1), .CHK_HI(HI1)) dut4 (
        .i_clk(clk), .i_rst_n(rstN), .i_en(en[1]), .o_rdy(rdy[1]),
        .i_mode(mode[1]), .i_chk_en(chk[1]),
        .o_s_addr(sAddr4), .i_s_rddata(sRd[1][3:0]), .o_s_wrdata(sWrdata4), .o_s_wren(sWren[1]),
        .o_ct_addr(ctAddr4), .i_ct_rddata(ctRd[1][3:0]),
        .o_pt_addr(ptAddr4), .i_pt_rddata(ptRd[1][3:0]), .o_pt_wrdata(ptWrdata4), .o_pt_wren(ptWren[1]),
        .o_valid(valid[1]), .o_fail_idx(failIdx4), .o_done(done[1])
    );

    assign sAddr[1]    = {4'h0, sAddr4};
    assign sWrdata[1]  = {4'h0, sWrdata4};
    assign ctAddr[1]   = {4'h0, ctAddr4};
    assign ptAddr[1]   = {4'h0, ptAddr4};
    assign ptWrdata[1] = {4'h0, ptWrdata4};
    assign failIdx[1]  = {4'h0, failIdx4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories with one-cycle read latency, plus a bench load port.
    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (sWren[n]) sMem[n][sAddr[n]] <= sWrdata[n];
            else if (ldS && ldInst == n) sMem[n][ldAddr] <= ldData;
            if (ldCt && ldInst == n) ctMem[n][ldAddr] <= ldData;
            if (ptWren[n]) ptMem[n][ptAddr[n]] <= ptWrdata[n];
            sRd[n]  <= sMem[n][sAddr[n]];
            ctRd[n] <= ctMem[n][ctAddr[n]];
            ptRd[n] <= ptMem[n][ptAddr[n]];
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Every PT write must match the next write the model predicted.
    always @(negedge clk) begin
        if (rstN) begin
            for (int n = 0; n < 2; n++) begin
                if (ptWren[n]) begin
                    if (expAddr.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL pt_extra: write addr 0x%0h data 0x%0h, expected no write",
                                 ptAddr[n], ptWrdata[n]);
                    end else begin
                        checkOutput("pt_addr", int'(ptAddr[n]), expAddr.pop_front());
                        checkOutput("pt_data", int'(ptWrdata[n]), expData.pop_front());
                    end
                end
            end
        end
    end

    // RC4 model: walks the message word by word on the bench copy of S.
    task automatic modelRun(input int n, input bit md, input bit ck);
        int m, len, i, j, t, pad, outv, lo, hi;
        m   = (n == 0) ? 255 : 15;
        lo  = (n == 0) ? LO0 : LO1;
        hi  = (n == 0) ? HI0 : HI1;
        len = ctBuf[0];
        i = 0;
        j = 0;
        expAddr.push_back(0);
        expData.push_back(len);
        expValid = 1;
        expFail  = 0;
        expBusy  = 2;
        for (int k = 1; k <= len; k++) begin
            i = (i + 1) & m;
            j = (j + mS[n][i]) & m;
            t = mS[n][i];
            mS[n][i] = mS[n][j];
            mS[n][j] = t;
            pad  = mS[n][(mS[n][i] + mS[n][j]) & m];
            outv = md ? pad : (ctBuf[k] ^ pad);
            expAddr.push_back(k);
            expData.push_back(outv);
            expBusy += 9;
            if (ck && !md && (outv < lo || outv > hi)) begin
                expValid = 0;
                expFail  = k;
                break;
            end
        end
    endtask

    task automatic loadMem(input int n, input bit toS, input int addr, input int data);
        ldInst = n;
        ldS    = toS;
        ldCt   = !toS;
        ldAddr = 8'(addr);
        ldData = 8'(data);
        if (toS) mS[n][addr] = data;
        @(negedge clk);
        ldS  = 1'b0;
        ldCt = 1'b0;
    endtask

    task automatic loadIdentity(input int n);
        int sz = (n == 0) ? 256 : 16;
        for (int a = 0; a < sz; a++) loadMem(n, 1'b1, a, a);
    endtask

    task automatic loadPerm(input int n);
        int p[256];
        int sz, b, t;
        sz = (n == 0) ? 256 : 16;
        for (int a = 0; a < sz; a++) p[a] = a;
        for (int a = sz - 1; a > 0; a--) begin
            b = $urandom_range(0, a);
            t = p[a];
            p[a] = p[b];
            p[b] = t;
        end
        for (int a = 0; a < sz; a++) loadMem(n, 1'b1, a, p[a]);
    endtask

    task automatic loadCt(input int n);
        for (int k = 0; k <= ctBuf[0]; k++) loadMem(n, 1'b0, k, ctBuf[k]);
    endtask

    // One run: start, check busy/done timing every cycle, then S contents.
    task automatic applyStimulus(input int n, input bit md, input bit ck, input bit holdEn);
        int sz, bad, sWrites;
        sz = (n == 0) ? 256 : 16;
        sWrites = 0;
        modelRun(n, md, ck);
        en[n]   = 1'b1;
        mode[n] = md;
        chk[n]  = ck;
        @(posedge clk);
        for (int c = 1; c <= expBusy + 1; c++) begin
            @(negedge clk);
            if (c <= expBusy) begin
                checkOutput("rdy_busy", int'(rdy[n]), 0);
                checkOutput("done_busy", int'(done[n]), 0);
                sWrites += int'(sWren[n]);
                en[n]   = ($urandom_range(0, 1) == 1);
                mode[n] = ($urandom_range(0, 1) == 1);
                chk[n]  = ($urandom_range(0, 1) == 1);
            end else begin
                checkOutput("done_pulse", int'(done[n]), 1);
                checkOutput("rdy_done", int'(rdy[n]), 1);
                checkOutput("valid", int'(valid[n]), expValid);
                checkOutput("fail_idx", int'(failIdx[n]), expFail);
                en[n] = holdEn;
            end
        end
        checkOutput("pt_writes_missing", expAddr.size(), 0);
        checkOutput("s_write_count", sWrites, 2 * ((expBusy - 2) / 9));
        bad = 0;
        for (int a = 0; a < sz; a++) if (int'(sMem[n][a]) != mS[n][a]) bad++;
        checkOutput("s_contents_bad", bad, 0);
    endtask

    // Start a run, pull reset during the first WRI cycle, and check immediate recovery.
    task automatic resetMidRun(input int n);
        int saved[256];
        saved = mS[n];
        modelRun(n, 1'b0, 1'b0);
        mS[n]   = saved;
        en[n]   = 1'b1;
        mode[n] = 1'b0;
        chk[n]  = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            en[n] = 1'b0;
        end
        checkOutput("rst_wren_before", int'(sWren[n]), 1);
        checkOutput("rst_valid_before", int'(valid[n]), 1);
        rstN = 1'b0;
        #1;
        checkOutput("rst_s_wren", int'(sWren[n]), 0);
        checkOutput("rst_rdy", int'(rdy[n]), 1);
        checkOutput("rst_valid", int'(valid[n]), 0);
        checkOutput("rst_fail_idx", int'(failIdx[n]), 0);
        checkOutput("rst_s_addr", int'(sAddr[n]), 0);
        expAddr.delete();
        expData.delete();
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic randomRuns(input int n, input int runs);
        bit held, md, ck, hold;
        int len, mask;
        held = 1'b0;
        mask = (n == 0) ? 255 : 15;
        for (int r = 0; r < runs; r++) begin
            md   = ($urandom_range(0, 1) == 1);
            ck   = ($urandom_range(0, 1) == 1);
            hold = (r < runs - 1) && ($urandom_range(0, 1) == 1);
            if (!held) begin
                if (r == 0) len = mask;
                else len = $urandom_range(0, (n == 0) ? 40 : 15);
                ctBuf[0] = len;
                for (int k = 1; k <= len; k++) ctBuf[k] = $urandom_range(0, mask);
                loadCt(n);
            end
            applyStimulus(n, md, ck, hold);
            held = hold;
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rstN   = 1'b0;
        en     = 2'b00;
        mode   = 2'b00;
        chk    = 2'b00;
        ldS    = 1'b0;
        ldCt   = 1'b0;
        ldInst = 0;
        ldAddr = 8'h00;
        ldData = 8'h00;
        @(negedge clk);
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            checkOutput("reset_rdy", int'(rdy[n]), 1);
            checkOutput("reset_valid", int'(valid[n]), 0);
            checkOutput("reset_fail_idx", int'(failIdx[n]), 0);
            checkOutput("reset_done", int'(done[n]), 0);
            checkOutput("reset_wrens", int'({sWren[n], ptWren[n]}), 0);
            checkOutput("reset_addrs", int'(sAddr[n] | ctAddr[n] | ptAddr[n] | sWrdata[n] | ptWrdata[n]), 0);
        end
        rstN = 1'b1;
        @(negedge clk);

        loadIdentity(0);
        ctBuf[0] = 3; ctBuf[1] = 'h41; ctBuf[2] = 'h42; ctBuf[3] = 'h43;
        loadCt(0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        checkOutput("xor_busy", expBusy, 29);
        checkOutput("xor_pt0", int'(ptMem[0][0]), 'h03);
        checkOutput("xor_pt1", int'(ptMem[0][1]), 'h43);
        checkOutput("xor_pt2", int'(ptMem[0][2]), 'h47);
        checkOutput("xor_pt3", int'(ptMem[0][3]), 'h44);
        checkOutput("xor_valid", int'(valid[0]), 1);

        loadIdentity(0);
        applyStimulus(0, 1'b1, 1'b0, 1'b0);
        checkOutput("ks_pt1", int'(ptMem[0][1]), 'h02);
        checkOutput("ks_pt2", int'(ptMem[0][2]), 'h05);
        checkOutput("ks_pt3", int'(ptMem[0][3]), 'h07);

        loadIdentity(0);
        ctBuf[2] = 0;
        loadCt(0);
        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        checkOutput("abort_busy", expBusy, 20);
        checkOutput("abort_pt1", int'(ptMem[0][1]), 'h43);
        checkOutput("abort_pt2", int'(ptMem[0][2]), 'h05);
        checkOutput("abort_pt3_untouched", int'(ptMem[0][3]), 'h07);
        checkOutput("abort_valid", int'(valid[0]), 0);
        checkOutput("abort_fail_idx", int'(failIdx[0]), 2);

        ctBuf[0] = 0;
        loadCt(0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        checkOutput("len0_busy", expBusy, 2);
        checkOutput("len0_pt0", int'(ptMem[0][0]), 0);
        checkOutput("len0_valid", int'(valid[0]), 1);

        ctBuf[0] = 3;
        loadCt(0);
        resetMidRun(0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0);

        loadPerm(0);
        randomRuns(0, 12);

        loadIdentity(1);
        ctBuf[0] = 2; ctBuf[1] = 3; ctBuf[2] = 0;
        loadCt(1);
        applyStimulus(1, 1'b0, 1'b0, 1'b1);
        checkOutput("w4_busy", expBusy, 20);
        checkOutput("w4_run1_pt1", int'(ptMem[1][1]), 1);
        checkOutput("w4_run1_pt2", int'(ptMem[1][2]), 5);
        applyStimulus(1, 1'b0, 1'b0, 1'b0);
        checkOutput("w4_run2_pt1", int'(ptMem[1][1]), 0);
        checkOutput("w4_run2_pt2", int'(ptMem[1][2]), 7);

        loadPerm(1);
        randomRuns(1, 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prga_stream.md
Name: prga_stream

Overview:
- Parametrised successor to the fixed 8-bit RC4 PRGA decryptor.
- Generates the RC4 keystream from a pre-scheduled S memory of 2^W words.
- Reads a length-prefixed ciphertext and writes a length-prefixed result to PT memory.
- Adds three things the fixed block lacks: a keystream-only mode, a printable-range check with early abort, and status outputs (valid, fail_idx, done) for the key-search controller.

Parameters:
- W, 8: word width. S depth is 2^W; S entries, message words, length word and all addresses are W bits wide.
- CHK_LO, 8'h20: lowest accepted plaintext value when the check is enabled.
- CHK_HI, 8'h7E: highest accepted plaintext value when the check is enabled.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  start request; sampled only when rdy=1.
- rdy  out  1  high when idle and able to accept en.
- mode  in  1  0 = XOR decrypt/encrypt; 1 = keystream only (pt = pad). Latched at start.
- chk_en  in  1  enables the printable check. Latched at start; ignored when mode=1.
- s_addr  out  W  S address.
- s_rddata  in  W  S read data.
- s_wrdata  out  W  S write data.
- s_wren  out  1  S write enable.
- ct_addr  out  W  CT address.
- ct_rddata  in  W  CT read data.
- pt_addr  out  W  PT address.
- pt_rddata  in  W  PT read data; unused.
- pt_wrdata  out  W  PT write data.
- pt_wren  out  1  PT write enable.
- valid  out  1  result of the last run: 1 = every checked word was in range.
- fail_idx  out  W  index of the first out-of-range word; 0 if none.
- done  out  1  one-cycle pulse on return to IDLE.

Behaviour:
- Memory timing: all memories read synchronously with 1-cycle latency. Data for an address driven in cycle n is valid in cycle n+1.
- Reset: rst_n=0 forces IDLE immediately, mid-run included. Reset values: rdy=1, valid=0, fail_idx=0, done=0, all addresses/wrdata 0, both wrens 0, i=j=0.
- Default outputs: in any state not listed below, every address and wrdata output drives 0 and both wrens are 0.
- IDLE:
  - rdy=1.
  - en=1 -> RDLEN, clears i, j, fail_idx, sets valid=1, latches mode and chk_en.
  - en is ignored while busy; dropping en mid-run does not abort.
- Start-up states:
  - RDLEN: ct_addr=0.
  - WRLEN: len captured from ct_rddata; pt_addr=0, pt_wrdata=len, pt_wren=1. Then k=1; if len=0 -> IDLE, else RDI.
- Per-word loop, 9 cycles per word, for word k:
  - RDI: i=i+1 (mod 2^W) registered on entry; s_addr=i.
  - WAITI: s_addr=i; capture si=s_rddata; j=j+si (mod 2^W) registered at exit.
  - RDJ: s_addr=j.
  - WAITJ: s_addr=j; capture sj.
  - WRI: s_addr=i, s_wrdata=sj, s_wren=1.
  - WRJ: s_addr=j, s_wrdata=si, s_wren=1. When i==j, both writes hit one address and the final value is si (which equals sj); this is correct.
  - RDP: s_addr=(si+sj) mod 2^W, ct_addr=k.
  - WAITP: s_addr and ct_addr held; capture pad=s_rddata and c=ct_rddata.
  - XOR: pt_addr=k, pt_wrdata = (mode ? pad : c^pad), pt_wren=1.
    - Check applies when chk_en=1 and mode=0. If pt_wrdata<CHK_LO or >CHK_HI and valid is still 1: the word is still written, valid<=0, fail_idx<=k, next state IDLE (abort).
    - Otherwise: if k==len -> IDLE, else k=k+1 -> RDI.
- Loop bounds: k runs 1..len; len=2^W-1 is legal and k never wraps.
- Latency: busy for 2+9*len cycles (2+9*k on abort). done=1 and rdy=1 in the first IDLE cycle after the run.
- Re-start: en held high at done starts a new run on the next edge. S is not re-initialised between runs.
- Status hold: valid and fail_idx hold until the next start or reset.

Test Plan:
1. Reset mid-run: assert rst_n=0 during WRI -> same cycle s_wren=0, rdy=1, valid=0, fail_idx=0. Next run after release behaves normally.
2. W=8, S identity, CT={3,41,42,43}h, mode=0, chk_en=0:
   - PT={03,43,47,44}h.
   - S[2]=03, S[3]=05, S[5]=02; step 1 exercises the i==j case.
   - done 29 cycles after the start edge; valid=1.
3. Same S and CT with mode=1 -> PT={03,02,05,07}h, valid=1.
4. ct[0]=0 -> pt[0]=0, no S access, done after 2 busy cycles, valid=1.
5. S identity, CT={3,41,00,43}h, chk_en=1:
   - PT[1]=43h written; PT[2]=05h written, then abort.
   - PT[3] untouched; valid=0, fail_idx=2, busy 20 cycles.
6. en held high through done -> second run starts next edge with i=j=0 on the S left by run 1. W=4 instance with CT={2,3,0} -> outputs stay 4-bit; all address arithmetic wraps mod 16.
